// File: rtl/imm_encode_if.sv
// Request/response bundle for imm_encode: a valid/ready request channel (sel + word)
// and a valid/ready result channel (field + flags).
interface imm_encode_if #(
    parameter int FIELD_W = 11
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_sel;
    logic [15:0]        in_value;
    logic               out_valid;
    logic               out_ready;
    logic [2:0]         out_sel;
    logic [FIELD_W-1:0] out_field;
    logic               out_ovf;
    logic               out_misalign;
    logic               out_bad_sel;

    modport master (
        output in_valid, in_sel, in_value, out_ready,
        input  in_ready, out_valid, out_sel, out_field, out_ovf, out_misalign, out_bad_sel
    );

    modport slave (
        input  in_valid, in_sel, in_value, out_ready,
        output in_ready, out_valid, out_sel, out_field, out_ovf, out_misalign, out_bad_sel
    );
endinterface

// File: rtl/imm_encode.sv
// Inverse LC-3b immediate/offset extender: two-stage valid/ready pipeline turning a word
// back into its right-justified instruction field. IMM_ENC_STATS_EN adds flag counters.
module imm_encode #(
    parameter int FIELD_W = 11
`ifdef IMM_ENC_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    imm_encode_if.slave        bus
`ifdef IMM_ENC_STATS_EN
    ,
    output logic [CNT_W-1:0]   ovf_count,
    output logic [CNT_W-1:0]   misalign_count
`endif
);

    typedef struct packed {
        logic [10:0] field;
        logic        ovf;
        logic        misalign;
        logic        bad_sel;
    } enc_t;

    // Field bits above the selected width stay zero; truncated bits survive even on ovf.
    function automatic enc_t encode(input logic [2:0] sel, input logic [15:0] v);
        enc_t        r;
        logic [15:0] s;
        r = '0;
        s = {v[15], v[15:1]};
        case (sel)
            3'd0: begin
                r.field    = {5'b00000, s[5:0]};
                r.ovf      = (s != {{10{s[5]}}, s[5:0]});
                r.misalign = v[0];
            end
            3'd1: begin
                r.field    = {2'b00, s[8:0]};
                r.ovf      = (s != {{7{s[8]}}, s[8:0]});
                r.misalign = v[0];
            end
            3'd2: begin
                r.field    = s[10:0];
                r.ovf      = (s != {{5{s[10]}}, s[10:0]});
                r.misalign = v[0];
            end
            3'd3: begin
                r.field = {6'b000000, v[4:0]};
                r.ovf   = (v != {{11{v[4]}}, v[4:0]});
            end
            3'd4: begin
                r.field = {7'b0000000, v[3:0]};
                r.ovf   = (v != {{12{v[3]}}, v[3:0]});
            end
            3'd5: begin
                r.field    = {3'b000, v[8:1]};
                r.ovf      = |v[15:9];
                r.misalign = v[0];
            end
            3'd6: begin
                r.field = {5'b00000, v[5:0]};
                r.ovf   = (v != {{10{v[5]}}, v[5:0]});
            end
            default: begin
                r.bad_sel = 1'b1;
            end
        endcase
        return r;
    endfunction

    logic               s1_valid_q, s1_valid_d;
    logic [2:0]         s1_sel_q, s1_sel_d;
    logic [15:0]        s1_value_q, s1_value_d;
    logic               out_valid_q, out_valid_d;
    logic [2:0]         out_sel_q, out_sel_d;
    logic [FIELD_W-1:0] out_field_q, out_field_d;
    logic               out_ovf_q, out_ovf_d;
    logic               out_misalign_q, out_misalign_d;
    logic               out_bad_sel_q, out_bad_sel_d;

    logic               s2_load_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               consume_s;
    enc_t               enc_s;

    // Handshake: ready is combinational from out_ready so a full pipe still streams.
    always_comb begin
        s2_load_s  = s1_valid_q & (~out_valid_q | bus.out_ready);
        in_ready_s = ~s1_valid_q | s2_load_s;
        accept_s   = bus.in_valid & in_ready_s;
        consume_s  = out_valid_q & bus.out_ready;
        enc_s      = encode(s1_sel_q, s1_value_q);
    end

    // Next-state for both pipeline stages.
    always_comb begin
        s1_valid_d     = s1_valid_q;
        s1_sel_d       = s1_sel_q;
        s1_value_d     = s1_value_q;
        out_valid_d    = out_valid_q;
        out_sel_d      = out_sel_q;
        out_field_d    = out_field_q;
        out_ovf_d      = out_ovf_q;
        out_misalign_d = out_misalign_q;
        out_bad_sel_d  = out_bad_sel_q;

        if (accept_s) begin
            s1_valid_d = 1'b1;
            s1_sel_d   = bus.in_sel;
            s1_value_d = bus.in_value;
        end else if (s2_load_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (s2_load_s) begin
            out_valid_d    = 1'b1;
            out_sel_d      = s1_sel_q;
            out_field_d    = FIELD_W'(enc_s.field);
            out_ovf_d      = enc_s.ovf;
            out_misalign_d = enc_s.misalign;
            out_bad_sel_d  = enc_s.bad_sel;
        end else if (consume_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_sel_q       <= 3'd0;
            s1_value_q     <= 16'h0000;
            out_valid_q    <= 1'b0;
            out_sel_q      <= 3'd0;
            out_field_q    <= '0;
            out_ovf_q      <= 1'b0;
            out_misalign_q <= 1'b0;
            out_bad_sel_q  <= 1'b0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_sel_q       <= s1_sel_d;
            s1_value_q     <= s1_value_d;
            out_valid_q    <= out_valid_d;
            out_sel_q      <= out_sel_d;
            out_field_q    <= out_field_d;
            out_ovf_q      <= out_ovf_d;
            out_misalign_q <= out_misalign_d;
            out_bad_sel_q  <= out_bad_sel_d;
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_sel      = out_sel_q;
    assign bus.out_field    = out_field_q;
    assign bus.out_ovf      = out_ovf_q;
    assign bus.out_misalign = out_misalign_q;
    assign bus.out_bad_sel  = out_bad_sel_q;

`ifdef IMM_ENC_STATS_EN
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;
    logic [CNT_W-1:0] misalign_count_q, misalign_count_d;

    // Saturating counters, bumped only when a flagged result is actually consumed.
    always_comb begin
        ovf_count_d      = ovf_count_q;
        misalign_count_d = misalign_count_q;
        if (consume_s && out_ovf_q && !(&ovf_count_q)) begin
            ovf_count_d = ovf_count_q + CNT_W'(1);
        end else begin
            ovf_count_d = ovf_count_q;
        end
        if (consume_s && out_misalign_q && !(&misalign_count_q)) begin
            misalign_count_d = misalign_count_q + CNT_W'(1);
        end else begin
            misalign_count_d = misalign_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count_q      <= '0;
            misalign_count_q <= '0;
        end else begin
            ovf_count_q      <= ovf_count_d;
            misalign_count_q <= misalign_count_d;
        end
    end

    assign ovf_count      = ovf_count_q;
    assign misalign_count = misalign_count_q;
`endif

endmodule
